// File: rtl/gb_bus_pkg.sv
// Shared definitions for the CPU external-bus responder: bus widths,
// T-state encodings, responder FSM states and the default ROM boundary.
package gb_bus_pkg;

    localparam int          GB_DATA_SIZE = 8;
    localparam int          GB_ADDR_SIZE = 16;
    localparam logic [15:0] GB_ROM_TOP   = 16'h8000;

    typedef enum logic [1:0] {
        T1 = 2'b00,
        T2 = 2'b01,
        T3 = 2'b10,
        T4 = 2'b11
    } t_state_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        DRIVE  = 3'd3,
        TAIL   = 3'd4
    } rsp_state_e;

endpackage

// File: rtl/gb_sync_ram.sv
// Single-port byte array with synchronous write and a registered read port.
// The array is named mem so benches can preload it hierarchically.
module gb_sync_ram #(
    parameter int DATA_SIZE = 8,
    parameter int AW        = 16,
    parameter int DEPTH     = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [AW-1:0]        addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gb_bus_responder.sv
// Memory-side responder for CPU read/write M-cycles with wait-state insertion.
// Optional ROM write protection below ROM_TOP is enabled by defining ROM_WP_EN.
module gb_bus_responder
    import gb_bus_pkg::*;
#(
    parameter int                    DATA_SIZE   = GB_DATA_SIZE,
    parameter int                    ADDR_SIZE   = GB_ADDR_SIZE,
    parameter int                    MEM_DEPTH   = 65536,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_SIZE-1:0]  ROM_TOP     = GB_ROM_TOP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           t_cycle,
    input  logic [ADDR_SIZE-1:0] addr_bus,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_oe,
    output logic                 hold,
    output logic                 wp_hit
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef ROM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    rsp_state_e     state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           is_wr_q, is_wr_d;
    logic [2:0]     wait_cnt_q, wait_cnt_d;
    logic           hold_q, hold_d;
    logic           data_oe_q, data_oe_d;
    logic           wp_hit_q, wp_hit_d;

    logic                 drive_go;
    logic                 wp_block;
    logic                 ram_we, ram_re;
    logic [ADDR_SIZE-1:0] addr_ext;

    assign addr_ext = ADDR_SIZE'(addr_q);
    assign wp_block = WP_ON && (addr_ext < ROM_TOP);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        wait_cnt_d = wait_cnt_q;
        data_oe_d  = data_oe_q;
        wp_hit_d   = 1'b0;
        drive_go   = 1'b0;

        case (state_q)
            IDLE: begin
                if (t_cycle == T1 && (rd || wr)) begin
                    addr_d     = addr_bus[AW-1:0];
                    is_wr_d    = wr & ~rd;
                    wait_cnt_d = 3'(WAIT_STATES);
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt_q == 3'd0) drive_go = 1'b1;
                else                    state_d  = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q == 3'd1) drive_go = 1'b1;
            end
            DRIVE: state_d = TAIL;
            TAIL: begin
                state_d   = IDLE;
                data_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // The RAM read/write happens on the same edge that enters DRIVE.
        if (drive_go) begin
            state_d   = DRIVE;
            data_oe_d = ~is_wr_q;
            wp_hit_d  = is_wr_q & wp_block;
        end

        hold_d = (state_d == WAIT);
    end

    assign ram_we = drive_go & is_wr_q & ~wp_block;
    assign ram_re = drive_go & ~is_wr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            wait_cnt_q <= '0;
            hold_q     <= 1'b0;
            data_oe_q  <= 1'b0;
            wp_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            wait_cnt_q <= wait_cnt_d;
            hold_q     <= hold_d;
            data_oe_q  <= data_oe_d;
            wp_hit_q   <= wp_hit_d;
        end
    end

    gb_sync_ram #(
        .DATA_SIZE (DATA_SIZE),
        .AW        (AW),
        .DEPTH     (MEM_DEPTH)
    ) mem (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (data_in),
        .rdata (data_out)
    );

    assign data_oe = data_oe_q;
    assign hold    = hold_q;
    assign wp_hit  = wp_hit_q;

endmodule

// File: doc/gb_bus_responder.md
Name: gb_bus_responder

Overview:
Memory-side responder for the CPU external bus. Answers CPU read/write M-cycles, sequenced by the CPU T-state, with a backing byte array and configurable wait-state insertion. It drives read data and a hold request back to the CPU decoder. It sits under top beside the CPU as the replacement for the bare mem array; the array stays hierarchically reachable as mem so benches can preload it.

Parameters:
DATA_SIZE, 8, data bus width
ADDR_SIZE, 16, address bus width
MEM_DEPTH, 65536, array depth in bytes (power of 2, at most 1<<ADDR_SIZE)
WAIT_STATES, 0, hold cycles inserted per access (0..7)
ROM_TOP, 16'h8000, first writable address (used only with ROM_WP_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
t_cycle  in  2  CPU T-state: 00=T1, 01=T2, 10=T3, 11=T4
addr_bus  in  ADDR_SIZE  CPU address
rd  in  1  CPU read strobe
wr  in  1  CPU write strobe
data_in  in  DATA_SIZE  CPU write data
data_out  out  DATA_SIZE  read data to CPU
data_oe  out  1  data_out valid
hold  out  1  stall request; CPU freezes t_cycle while high
wp_hit  out  1  one-cycle pulse on a dropped ROM write

Behaviour:
- Reset (rst low, async): state=IDLE, data_out=0, data_oe=0, hold=0, wait_cnt=0, wp_hit=0. mem contents are not reset. A reset mid-access abandons the access, and no write is committed.
- States: IDLE, ACCESS, WAIT, DRIVE, TAIL.
- IDLE: on a clk edge with t_cycle==00 and (rd|wr):
  - latch addr_q = addr_bus[log2(MEM_DEPTH)-1:0], so addresses wrap modulo MEM_DEPTH;
  - latch is_wr = wr & ~rd (rd wins if both are high; no write occurs);
  - wait_cnt <= WAIT_STATES;
  - go to ACCESS.
- ACCESS (CPU T2):
  - wait_cnt==0 -> DRIVE.
  - else -> WAIT.
- WAIT:
  - hold=1, a registered output equal to (state==WAIT).
  - wait_cnt decrements each cycle; at wait_cnt==1 -> DRIVE.
  - Result: hold is high for exactly WAIT_STATES cycles.
- Entry to DRIVE (same edge):
  - read: data_out <= mem[addr_q], data_oe <= 1.
  - write: mem[addr_q] <= data_in sampled on this edge; data_oe stays 0.
- DRIVE (T3) -> TAIL (T4). data_out is held stable through both states.
- TAIL -> IDLE; data_oe <= 0 on that edge.
  - data_out retains its last value.
  - Reads of uninitialised locations return x in simulation; benches use this as end-of-program.
- Latency: read data valid 2+WAIT_STATES cycles after the T1 edge that launched the access.
- Strobes seen outside IDLE, or in IDLE with t_cycle!=00, are ignored. There is no queuing; one access per M-cycle.
- Back-to-back M-cycles: the edge leaving TAIL goes to IDLE. A T1 on the very next edge starts a new access.

Optional Feature:
ROM_WP_EN:
- Defined: writes with addr_q < ROM_TOP are dropped. wp_hit pulses high for one cycle on the DRIVE-entry edge. The state sequence is unchanged.
- Undefined: all writes commit, and wp_hit is tied 0.

Decomposition:
- Package gb_bus_pkg:
  - DATA_SIZE/ADDR_SIZE defaults;
  - T-state encodings T1..T4;
  - responder state enum;
  - ROM_TOP default.
- One sub-module, gb_sync_ram: single-port array named mem, synchronous write, registered read. It is instantiated as mem so hierarchical preload paths stay valid. The FSM and wait counter stay in gb_bus_responder.

Test Plan:
- Preload mem[16'h0100]=8'h3E, WAIT_STATES=0, rd at T1 addr 0100 -> data_oe high two edges later, data_out=8'h3E through T3/T4, hold never high.
- wr at T1 addr C000 data_in 8'hA5, then read C000 next M-cycle -> data_out=8'hA5; mem[C000]=8'hA5 after the DRIVE edge.
- WAIT_STATES=3, read 0200 -> hold high exactly 3 consecutive cycles; data_oe rises on the 5th edge after T1.
- rd and wr both high at T1, addr C001, mem=8'h11, data_in 8'hFF -> read returns 8'h11; mem[C001] stays 8'h11.
- Drop rst low while in WAIT during a write to C002 -> hold, data_oe, data_out go to 0 immediately; mem[C002] is unchanged.
- ROM_WP_EN defined: write 8'h55 to 0x0150 -> mem unchanged, one-cycle wp_hit. Without the macro: mem[0150]=8'h55, wp_hit=0.
